cache_mem_bridge: RTL and testbench
===================================

CACHE_MEM_BRIDGE -- requirements
Module: cache_mem_bridge

Interface
REQ-001 Parameter WORD_W, 32, data word width in bits.
REQ-002 Parameter MEM_AW, 13, main-memory word-address width (8K words).
REQ-003 Parameter BEAT_W, 3, beat-offset width (8 words per block).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  cache miss handler requests one block transfer.
REQ-007 req_ready  out  1  bridge accepts a request this cycle.
REQ-008 req_write  in  1  1 = writeback (cache to memory), 0 = refill (memory to cache).
REQ-009 req_block_addr  in  MEM_AW-BEAT_W (10)  block address; memory word address = {block, beat}.
REQ-010 wr_data  in  WORD_W  writeback word for the current beat_offset; combinationally forwarded to mem_a_din.
REQ-011 wr_data_rd  out  1  bridge consumes wr_data this cycle.
REQ-012 rd_data  out  WORD_W  refill word.
REQ-013 rd_valid  out  1  rd_data valid for beat_offset this cycle.
REQ-014 beat_offset  out  BEAT_W  beat index qualified by wr_data_rd or rd_valid.
REQ-015 done  out  1  one-cycle pulse; block transfer complete.
REQ-016 mem_a_en / mem_a_we  out  1 / 1  memory port A enable and write enable.
REQ-017 mem_a_addr  out  MEM_AW  port A word address.
REQ-018 mem_a_din / mem_a_dout  out / in  WORD_W  port A write data / read data (synchronous read, 1-cycle latency).
REQ-019 refill_cnt / wb_cnt  out  16 / 16  completed refill / writeback counts.

Function
REQ-020 States: IDLE, WRITE, READ, DRAIN, DONE.
REQ-021 req_ready is 1 only in IDLE; a request is accepted on a rising edge where req_valid & req_ready, latching req_write and req_block_addr.
REQ-022 Accept at edge E0 with req_write=1: WRITE for cycles 1-8 with mem_a_en=mem_a_we=wr_data_rd=1 and beat_offset 0..7; DONE in cycle 9 (done=1); IDLE in cycle 10.
REQ-023 Accept at edge E0 with req_write=0: READ for cycles 1-8 with mem_a_en=1, mem_a_we=0 and address beats 0..7; rd_valid=1 in cycles 2-9 with beat_offset 0..7 and rd_data=mem_a_dout.
REQ-024 DRAIN occupies cycle 9, delivering beat 7 with done=1 in that same cycle; IDLE in cycle 10.
REQ-025 mem_a_addr = {latched block, beat counter}; the beat counter wraps 7->0 only on state exit, never inside a burst.
REQ-026 Each request costs exactly 9 busy cycles; back-to-back requests are accepted no earlier than cycle 10.
REQ-027 req_valid while busy is ignored; no request is queued.
REQ-028 Outside active beats: mem_a_en, mem_a_we, wr_data_rd, rd_valid and done are 0; rd_data holds its last value.
REQ-029 refill_cnt increments in DRAIN, wb_cnt in DONE, and both saturate at 16'hFFFF.

Reset
REQ-030 rst asserted forces IDLE immediately; all outputs become 0 except req_ready=1; beat counter, latched request and both counters clear.
REQ-031 Reset mid-burst aborts the transfer: done is not generated, and memory holds any words already written.
REQ-032 The first request is accepted on the first rising edge after rst deasserts.

Structure
REQ-033 The shared package cache_pkg holds WORD_W, MEM_AW, BEAT_W, the block-address width and the state enum; SimpleCache imports the same constants.
REQ-034 No sub-module; the beat counter and FSM are inline. Target size is 150-250 RTL lines.

Verification
REQ-035 Writeback of block 10'd79 (tag 1, index 15), wr_data=100+beat -> memory words 632..639 hold 100..107; done appears in cycle 9 only.
REQ-036 Refill of block 79 after REQ-035 -> rd_valid in cycles 2-9, rd_data 100..107 with beat_offset 0..7; done coincides with beat 7.
REQ-037 Hold req_valid high continuously for a writeback to block 84 followed by a refill of block 84 -> req_ready=0 in cycles 1-9 and the second request is accepted at cycle 10 with data 200..207 returned.
REQ-038 Assert rst in cycle 4 of a writeback -> all outputs clear immediately with no done; words 0..2 are updated and words 3..7 are unchanged.
REQ-039 Preload wb_cnt to 16'hFFFE via 65534 writebacks (forced), then run 3 writebacks -> wb_cnt stays at 16'hFFFF.
REQ-040 Refill of block 10'd1023 -> mem_a_addr runs 8184..8191 with no address wrap.

Source files
------------

// File: rtl/cache_pkg.sv
`timescale 1ns/1ps
// cache_pkg: constants and types shared by the cache block-transfer logic.
//   WORD_W  - data word width
//   MEM_AW  - main-memory word-address width
//   BEAT_W  - beat-offset width (words per block = 2**BEAT_W)
//   BLK_AW  - block-address width
//   CNT_W   - width of the completed-transfer counters
//   bridge_state_e - block-transfer FSM states
//   sat_inc - saturating counter increment
package cache_pkg;

    localparam int WORD_W = 32;
    localparam int MEM_AW = 13;
    localparam int BEAT_W = 3;
    localparam int BLK_AW = MEM_AW - BEAT_W;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bridge_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == {CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_mem_bridge.sv
`timescale 1ns/1ps
// cache_mem_bridge: moves one cache block between the miss handler and a
// single-port synchronous-read main memory, one word per cycle.
//   clk, rst                  - clock, asynchronous active-high reset
//   req_valid/req_ready       - block-transfer request handshake
//   req_write, req_block_addr - direction (1 = writeback) and block address
//   wr_data / wr_data_rd      - writeback word for beat_offset / consumed strobe
//   rd_data / rd_valid        - refill word for beat_offset / valid strobe
//   beat_offset               - beat index qualifying wr_data_rd or rd_valid
//   done                      - one-cycle completion pulse
//   mem_a_*                   - memory port A (1-cycle read latency)
//   refill_cnt, wb_cnt        - saturating completed-transfer counters
module cache_mem_bridge #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int MEM_AW = cache_pkg::MEM_AW,
    parameter int BEAT_W = cache_pkg::BEAT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [MEM_AW-BEAT_W-1:0]  req_block_addr,
    input  logic [WORD_W-1:0]         wr_data,
    output logic                      wr_data_rd,
    output logic [WORD_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic [BEAT_W-1:0]         beat_offset,
    output logic                      done,
    output logic                      mem_a_en,
    output logic                      mem_a_we,
    output logic [MEM_AW-1:0]         mem_a_addr,
    output logic [WORD_W-1:0]         mem_a_din,
    input  logic [WORD_W-1:0]         mem_a_dout,
    output logic [15:0]               refill_cnt,
    output logic [15:0]               wb_cnt
);

    import cache_pkg::*;

    localparam int BLK_W = MEM_AW - BEAT_W;

    bridge_state_e          state_r;
    bridge_state_e          state_s;
    logic                   accept_s;
    logic                   last_beat_s;
    logic [BEAT_W-1:0]      beat_r;
    logic [BLK_W-1:0]       blk_r;
    logic                   rd_pend_r;
    logic [BEAT_W-1:0]      rd_beat_r;
    logic [WORD_W-1:0]      rd_hold_r;
    logic [15:0]            refill_cnt_r;
    logic [15:0]            wb_cnt_r;
    logic [BEAT_W-1:0]      beat_offset_s;

    assign last_beat_s = (beat_r == {BEAT_W{1'b1}});

    // Next-state decode; the request is accepted only from IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = req_write ? ST_WRITE : ST_READ;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (last_beat_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (last_beat_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: state_s = ST_IDLE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM state, beat counter and latched block address.
    // The beat counter only advances on active beats, so its natural 7->0
    // wrap coincides with leaving WRITE/READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            beat_r  <= {BEAT_W{1'b0}};
            blk_r   <= {BLK_W{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_r == ST_WRITE) || (state_r == ST_READ)) begin
                beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
            end else begin
                beat_r <= {BEAT_W{1'b0}};
            end
            if (accept_s) begin
                blk_r <= req_block_addr;
            end
        end
    end

    // Read-return tracking: memory answers one cycle after the address,
    // so the beat index and valid flag are delayed by one cycle; the last
    // returned word is held for rd_data between bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r <= 1'b0;
            rd_beat_r <= {BEAT_W{1'b0}};
            rd_hold_r <= {WORD_W{1'b0}};
        end else begin
            rd_pend_r <= (state_r == ST_READ);
            rd_beat_r <= beat_r;
            if (rd_pend_r) begin
                rd_hold_r <= mem_a_dout;
            end
        end
    end

    // Completed-transfer counters, bumped in the final cycle of each burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refill_cnt_r <= 16'd0;
            wb_cnt_r     <= 16'd0;
        end else begin
            if (state_r == ST_DRAIN) begin
                refill_cnt_r <= sat_inc(refill_cnt_r);
            end
            if (state_r == ST_DONE) begin
                wb_cnt_r <= sat_inc(wb_cnt_r);
            end
        end
    end

    // Beat index: read returns take priority, else the active write beat.
    always_comb begin
        beat_offset_s = {BEAT_W{1'b0}};
        if (rd_pend_r) begin
            beat_offset_s = rd_beat_r;
        end else if (state_r == ST_WRITE) begin
            beat_offset_s = beat_r;
        end else begin
            beat_offset_s = {BEAT_W{1'b0}};
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign mem_a_en    = (state_r == ST_WRITE) || (state_r == ST_READ);
    assign mem_a_we    = (state_r == ST_WRITE);
    assign wr_data_rd  = (state_r == ST_WRITE);
    assign mem_a_addr  = {blk_r, beat_r};
    assign mem_a_din   = (state_r == ST_WRITE) ? wr_data : {WORD_W{1'b0}};
    assign rd_valid    = rd_pend_r;
    assign rd_data     = rd_pend_r ? mem_a_dout : rd_hold_r;
    assign beat_offset = beat_offset_s;
    assign done        = (state_r == ST_DRAIN) || (state_r == ST_DONE);
    assign refill_cnt  = refill_cnt_r;
    assign wb_cnt      = wb_cnt_r;

endmodule

// File: tb/tb_cache_mem_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for cache_mem_bridge: directed scenarios plus random
// block transfers against an array-based memory reference.
module tb_cache_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_block_addr;
    logic [31:0] wr_data;
    logic        wr_data_rd;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  beat_offset;
    logic        done;
    logic        mem_a_en;
    logic        mem_a_we;
    logic [12:0] mem_a_addr;
    logic [31:0] mem_a_din;
    logic [31:0] mem_a_dout;
    logic [15:0] refill_cnt;
    logic [15:0] wb_cnt;

    logic [31:0] wb_buf [8];
    bit   [31:0] mem [8192];
    bit   [31:0] ref_mem [8192];
    int          n_checks;
    int          n_err;
    int          refill_m;
    int          wb_m;

    cache_mem_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_block_addr (req_block_addr),
        .wr_data        (wr_data),
        .wr_data_rd     (wr_data_rd),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .beat_offset    (beat_offset),
        .done           (done),
        .mem_a_en       (mem_a_en),
        .mem_a_we       (mem_a_we),
        .mem_a_addr     (mem_a_addr),
        .mem_a_din      (mem_a_din),
        .mem_a_dout     (mem_a_dout),
        .refill_cnt     (refill_cnt),
        .wb_cnt         (wb_cnt)
    );

    always #5 clk = ~clk;

    // Writeback source: the cache supplies the word for the current beat.
    assign wr_data = wb_buf[beat_offset];

    // Main memory: synchronous read with one cycle of latency.
    always @(posedge clk) begin
        if (mem_a_en) begin
            if (mem_a_we) begin
                mem[mem_a_addr] <= mem_a_din;
            end
            mem_a_dout <= mem[mem_a_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string name, input int k);
        return $sformatf("%s_c%0d", name, k);
    endfunction

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"},  req_ready,   1);
        chk({tag, "_mem_a_en"},   mem_a_en,    0);
        chk({tag, "_mem_a_we"},   mem_a_we,    0);
        chk({tag, "_wr_data_rd"}, wr_data_rd,  0);
        chk({tag, "_rd_valid"},   rd_valid,    0);
        chk({tag, "_done"},       done,        0);
        chk({tag, "_mem_a_addr"}, mem_a_addr,  0);
        chk({tag, "_mem_a_din"},  mem_a_din,   0);
        chk({tag, "_rd_data"},    rd_data,     0);
        chk({tag, "_beat"},       beat_offset, 0);
        chk({tag, "_refill_cnt"}, refill_cnt,  0);
        chk({tag, "_wb_cnt"},     wb_cnt,      0);
    endtask

    // One block transfer starting at a falling edge with the bridge idle.
    // keep: leave req_valid high; nwr/nblk: values driven while busy.
    // abort_k: cycle in which rst is raised (0 = never).
    task automatic do_req(input bit wr, input logic [9:0] blk, input bit keep,
                          input bit nwr, input logic [9:0] nblk, input int abort_k);
        int base;
        bit act;
        bit rv;
        base           = int'(blk) * 8;
        req_write      = wr;
        req_block_addr = blk;
        req_valid      = 1'b1;
        chk("ready_before_accept", req_ready, 1);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst       = 1'b1;
                req_valid = 1'b0;
                #1;
                check_reset_state("abort");
                for (int b = 0; b < k - 1; b++) begin
                    ref_mem[base + b] = wb_buf[b];
                end
                refill_m = 0;
                wb_m     = 0;
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    chk("abort_no_en", mem_a_en, 0);
                    chk("abort_ready", req_ready, 1);
                end
                return;
            end
            act = (k <= 8);
            rv  = !wr && (k >= 2) && (k <= 9);
            if (k == 10) begin
                if (wr) begin
                    wb_m = sat16(wb_m);
                end else begin
                    refill_m = sat16(refill_m);
                end
            end
            chk(tg("req_ready", k),  req_ready,  (k == 10));
            chk(tg("mem_a_en", k),   mem_a_en,   act);
            chk(tg("mem_a_we", k),   mem_a_we,   act && wr);
            chk(tg("wr_data_rd", k), wr_data_rd, act && wr);
            chk(tg("rd_valid", k),   rd_valid,   rv);
            chk(tg("done", k),       done,       (k == 9));
            if (act) begin
                chk(tg("mem_a_addr", k), mem_a_addr, 64'(base + k - 1));
            end
            if (act && wr) begin
                chk(tg("wr_beat", k),   beat_offset, 64'(k - 1));
                chk(tg("mem_a_din", k), mem_a_din,   wb_buf[k - 1]);
            end
            if (rv) begin
                chk(tg("rd_beat", k), beat_offset, 64'(k - 2));
                chk(tg("rd_data", k), rd_data,     ref_mem[base + k - 2]);
            end
            if (k == 10) begin
                if (!wr) begin
                    chk("rd_data_hold", rd_data, ref_mem[base + 7]);
                end
                chk("refill_cnt", refill_cnt, 64'(refill_m));
                chk("wb_cnt",     wb_cnt,     64'(wb_m));
            end
            if (k == 1) begin
                if (!keep) begin
                    req_valid = 1'b0;
                end
                req_write      = nwr;
                req_block_addr = nblk;
            end
        end
        if (wr) begin
            for (int b = 0; b < 8; b++) begin
                ref_mem[base + b] = wb_buf[b];
            end
        end
    endtask

    logic [9:0] blk_tab [6];

    initial begin
        n_checks       = 0;
        n_err          = 0;
        refill_m       = 0;
        wb_m           = 0;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_block_addr = 10'd0;
        for (int b = 0; b < 8; b++) wb_buf[b] = 32'd0;
        blk_tab[0] = 10'd5;   blk_tab[1] = 10'd79;  blk_tab[2] = 10'd84;
        blk_tab[3] = 10'd512; blk_tab[4] = 10'd1023; blk_tab[5] = 10'd6;

        #1;
        check_reset_state("por");

        // Release reset and request on the very next edge.
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 8; b++) wb_buf[b] = 32'(100 + b);
        do_req(1'b1, 10'd79, 1'b0, 1'b0, 10'd0, 0);
        for (int b = 0; b < 8; b++) chk($sformatf("mem_%0d", 632 + b), mem[632 + b], 64'(100 + b));
        do_req(1'b0, 10'd79, 1'b0, 1'b1, 10'd3, 0);

        // Back-to-back with req_valid held; busy-time input changes ignored.
        for (int b = 0; b < 8; b++) wb_buf[b] = 32'(200 + b);
        do_req(1'b1, 10'd84, 1'b1, 1'b0, 10'd84, 0);
        do_req(1'b0, 10'd84, 1'b0, 1'b0, 10'd0, 0);
        for (int b = 0; b < 8; b++) chk($sformatf("mem84_%0d", b), mem[672 + b], 64'(200 + b));

        // Top block: addresses 8184..8191, no wrap.
        for (int b = 0; b < 8; b++) wb_buf[b] = $urandom;
        do_req(1'b1, 10'd1023, 1'b0, 1'b0, 10'd0, 0);
        do_req(1'b0, 10'd1023, 1'b0, 1'b1, 10'd1, 0);

        // Random transfers over a small block set.
        for (int i = 0; i < 16; i++) begin
            bit         rw;
            logic [9:0] blk;
            rw  = 1'($urandom_range(0, 1));
            blk = blk_tab[$urandom_range(0, 5)];
            if (rw) begin
                for (int b = 0; b < 8; b++) wb_buf[b] = $urandom;
            end
            do_req(rw, blk, 1'b0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 0);
        end

        // Reset in cycle 4 of a writeback: beats 0..2 land, 3..7 untouched.
        do_req(1'b1, 10'd84, 1'b0, 1'b0, 10'd0, 0);
        for (int b = 0; b < 8; b++) wb_buf[b] = 32'(300 + b);
        do_req(1'b1, 10'd84, 1'b0, 1'b0, 10'd0, 4);
        for (int b = 0; b < 3; b++) chk($sformatf("abort_new_%0d", b), mem[672 + b], 64'(300 + b));
        for (int b = 3; b < 8; b++) chk($sformatf("abort_old_%0d", b), mem[672 + b], ref_mem[672 + b]);
        do_req(1'b0, 10'd84, 1'b0, 1'b0, 10'd0, 0);

        // Writeback counter saturation from a preloaded 16'hFFFE.
        force dut.wb_cnt_r = 16'hFFFE;
        #1;
        release dut.wb_cnt_r;
        wb_m = 65534;
        chk("wb_cnt_preload", wb_cnt, 64'h0000_0000_0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 8; b++) wb_buf[b] = $urandom;
            do_req(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 0);
        end
        chk("wb_cnt_saturated", wb_cnt, 64'h0000_0000_0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
